lcd_text_driver: RTL

- Self-sequencing HD44780-style 8-bit character-LCD driver.
- Performs the power-up init sequence, then refreshes both display lines continuously.
- Line 1 shows the current mode name. Line 2 shows HH:MM:SS from BCD inputs, with per-field blinking for setting mode.
- Sits between the mode/time core and the board LCD pins. It is the generalised successor of the mode-name character ROM: configurable line length and step timing, with full bus sequencing.

---
 rtl/lcd_text_driver.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_text_driver.sv
// HD44780-style 8-bit character LCD driver: power-up init, then continuous two-line refresh
// of the mode name (line 1) and HH:MM:SS (line 2) with per-field blinking.
module lcd_text_driver #(
  parameter int CLK_DIV      = 50,
  parameter int PWR_STEPS    = 400,
  parameter int CLR_STEPS    = 40,
  parameter int LINE_LEN     = 16,
  parameter int BLINK_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [23:0] time_bcd,
  input  logic [2:0]  blink_en,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        init_done,
  output logic        frame_done
);

  localparam int DW   = $clog2(CLK_DIV);
  localparam int MAXS = (PWR_STEPS > CLR_STEPS) ? ((PWR_STEPS > LINE_LEN) ? PWR_STEPS : LINE_LEN)
                                                : ((CLR_STEPS > LINE_LEN) ? CLR_STEPS : LINE_LEN);
  localparam int CW   = $clog2(MAXS);
  localparam int FW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_STEPS - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_STEPS - 1);
  localparam logic [CW-1:0] CHR_LAST = CW'(LINE_LEN - 1);
  localparam logic [FW-1:0] BLK_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [3:0] S_PWR_WAIT = 4'd0;
  localparam logic [3:0] S_FUNC_SET = 4'd1;
  localparam logic [3:0] S_DISP_ON  = 4'd2;
  localparam logic [3:0] S_ENTRY    = 4'd3;
  localparam logic [3:0] S_CLEAR    = 4'd4;
  localparam logic [3:0] S_CLR_WAIT = 4'd5;
  localparam logic [3:0] S_L1_ADDR  = 4'd6;
  localparam logic [3:0] S_L1_CHAR  = 4'd7;
  localparam logic [3:0] S_L2_ADDR  = 4'd8;
  localparam logic [3:0] S_L2_CHAR  = 4'd9;

  localparam logic [95:0] TXT_WATCH = "MODE1: WATCH";
  localparam logic [95:0] TXT_ALARM = "MODE2: ALARM";
  localparam logic [95:0] TXT_STOP  = "MODE3: STOP ";
  localparam logic [95:0] TXT_SET   = "MODE4: SET  ";

  logic [DW-1:0] div_r, div_nxt_s;
  logic [3:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]    snap_mode_r;
  logic [23:0]   snap_time_r;
  logic [2:0]    snap_blink_r;
  logic [FW-1:0] fcnt_r;
  logic          phase_r;
  logic          step_end_s, frame_end_s, is_wr_s, rs_nxt_s;
  logic [7:0]    data_nxt_s;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  function automatic logic [7:0] line1_char(input logic [1:0] m, input logic [CW-1:0] p);
    logic [95:0] s;
    int          idx;
    case (m)
      2'd0:    s = TXT_WATCH;
      2'd1:    s = TXT_ALARM;
      2'd2:    s = TXT_STOP;
      default: s = TXT_SET;
    endcase
    if (p < CW'(12)) begin
      idx = 11 - int'(p);
      return s[idx*8 +: 8];
    end else begin
      return 8'h20;
    end
  endfunction

  // Colons are never blanked; a digit blanks only while its field's blink bit and the phase are set.
  function automatic logic [7:0] line2_char(input logic [23:0] t, input logic [2:0] b,
                                            input logic ph, input logic [CW-1:0] p);
    logic [3:0] nib;
    logic       blank;
    logic [7:0] c;
    nib   = 4'h0;
    blank = 1'b0;
    c     = 8'h20;
    case (p)
      CW'(0):  begin nib = t[23:20]; blank = b[2]; c = 8'h00; end
      CW'(1):  begin nib = t[19:16]; blank = b[2]; c = 8'h00; end
      CW'(2):  c = 8'h3A;
      CW'(3):  begin nib = t[15:12]; blank = b[1]; c = 8'h00; end
      CW'(4):  begin nib = t[11:8];  blank = b[1]; c = 8'h00; end
      CW'(5):  c = 8'h3A;
      CW'(6):  begin nib = t[7:4];   blank = b[0]; c = 8'h00; end
      CW'(7):  begin nib = t[3:0];   blank = b[0]; c = 8'h00; end
      default: c = 8'h20;
    endcase
    if (c == 8'h00) begin
      c = (ph && blank) ? 8'h20 : digit_char(nib);
    end else begin
      c = c;
    end
    return c;
  endfunction

  assign step_end_s  = (div_r == DIV_LAST);
  assign div_nxt_s   = step_end_s ? '0 : (div_r + DW'(1));
  assign frame_end_s = step_end_s && (state_r == S_L2_CHAR) && (cnt_r == CHR_LAST);
  assign is_wr_s     = (state_r != S_PWR_WAIT) && (state_r != S_CLR_WAIT);
  assign lcd_rw      = 1'b0;

  // Step sequencing: state and step counter advance only at the end of a step.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (step_end_s) begin
      case (state_r)
        S_PWR_WAIT: if (cnt_r == PWR_LAST) begin state_nxt_s = S_FUNC_SET; cnt_nxt_s = '0; end
                    else cnt_nxt_s = cnt_r + CW'(1);
        S_FUNC_SET: state_nxt_s = S_DISP_ON;
        S_DISP_ON:  state_nxt_s = S_ENTRY;
        S_ENTRY:    state_nxt_s = S_CLEAR;
        S_CLEAR:    begin state_nxt_s = S_CLR_WAIT; cnt_nxt_s = '0; end
        S_CLR_WAIT: if (cnt_r == CLR_LAST) begin state_nxt_s = S_L1_ADDR; cnt_nxt_s = '0; end
                    else cnt_nxt_s = cnt_r + CW'(1);
        S_L1_ADDR:  begin state_nxt_s = S_L1_CHAR; cnt_nxt_s = '0; end
        S_L1_CHAR:  if (cnt_r == CHR_LAST) begin state_nxt_s = S_L2_ADDR; cnt_nxt_s = '0; end
                    else cnt_nxt_s = cnt_r + CW'(1);
        S_L2_ADDR:  begin state_nxt_s = S_L2_CHAR; cnt_nxt_s = '0; end
        S_L2_CHAR:  if (cnt_r == CHR_LAST) begin state_nxt_s = S_L1_ADDR; cnt_nxt_s = '0; end
                    else cnt_nxt_s = cnt_r + CW'(1);
        default:    begin state_nxt_s = S_PWR_WAIT; cnt_nxt_s = '0; end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Bus contents of the upcoming step; loaded into the pins as that step begins.
  always_comb begin
    rs_nxt_s   = 1'b0;
    data_nxt_s = 8'h00;
    case (state_nxt_s)
      S_FUNC_SET: data_nxt_s = 8'h38;
      S_DISP_ON:  data_nxt_s = 8'h0C;
      S_ENTRY:    data_nxt_s = 8'h06;
      S_CLEAR:    data_nxt_s = 8'h01;
      S_L1_ADDR:  data_nxt_s = 8'h80;
      S_L1_CHAR:  begin rs_nxt_s = 1'b1; data_nxt_s = line1_char(snap_mode_r, cnt_nxt_s); end
      S_L2_ADDR:  data_nxt_s = 8'hC0;
      S_L2_CHAR:  begin
                    rs_nxt_s   = 1'b1;
                    data_nxt_s = line2_char(snap_time_r, snap_blink_r, phase_r, cnt_nxt_s);
                  end
      default:    begin rs_nxt_s = 1'b0; data_nxt_s = 8'h00; end
    endcase
  end

  // Sequencer, bus outputs, input snapshot and blink timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r        <= '0;
      state_r      <= S_PWR_WAIT;
      cnt_r        <= '0;
      snap_mode_r  <= 2'd0;
      snap_time_r  <= 24'h000000;
      snap_blink_r <= 3'b000;
      fcnt_r       <= '0;
      phase_r      <= 1'b0;
      lcd_e        <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_data     <= 8'h00;
      init_done    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      div_r      <= div_nxt_s;
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      lcd_e      <= is_wr_s && (div_nxt_s >= DW'(1)) && (div_nxt_s <= DIV_HALF);
      frame_done <= (div_nxt_s == DIV_LAST) && (state_r == S_L2_CHAR) && (cnt_r == CHR_LAST);
      if (step_end_s) begin
        lcd_rs   <= rs_nxt_s;
        lcd_data <= data_nxt_s;
      end else begin
        lcd_rs   <= lcd_rs;
        lcd_data <= lcd_data;
      end
      if (step_end_s && (state_nxt_s == S_L1_ADDR)) begin
        snap_mode_r  <= mode;
        snap_time_r  <= time_bcd;
        snap_blink_r <= blink_en;
        init_done    <= 1'b1;
      end else begin
        snap_mode_r  <= snap_mode_r;
        snap_time_r  <= snap_time_r;
        snap_blink_r <= snap_blink_r;
        init_done    <= init_done;
      end
      if (frame_end_s) begin
        if (fcnt_r == BLK_LAST) begin
          fcnt_r  <= '0;
          phase_r <= ~phase_r;
        end else begin
          fcnt_r  <= fcnt_r + FW'(1);
        end
      end else begin
        fcnt_r  <= fcnt_r;
        phase_r <= phase_r;
      end
    end
  end

endmodule
